hand_point_gen: RTL and testbench
=================================

HAND_POINT_GEN -- requirements
Module: hand_point_gen

Interface
REQ-001 SHALL have parameter CX, default 320: clock-face centre x in pixels.
REQ-002 SHALL have parameter CY, default 240: clock-face centre y in pixels.
REQ-003 SHALL have parameter RW, default 8: radius width in bits.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; port clk, input, 1 bit: sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1 bit: request present.
REQ-007 SHALL have port req_ready, output, 1 bit: block can accept a request.
REQ-008 SHALL have port req_angle, input, 9 bits: angle in degrees, 0..511.
REQ-009 SHALL have port req_radius, input, RW bits: unsigned hand length in pixels.
REQ-010 SHALL have port cordic_start, output, 1 bit: one-cycle start pulse to the sin/cos stage.
REQ-011 SHALL have port cordic_angle, output, 9 bits: reduced angle, 0..359.
REQ-012 SHALL have port cordic_done, input, 1 bit: sin/cos result valid.
REQ-013 SHALL have port cordic_sin, input, 9 bits, signed: sine, value/256.
REQ-014 SHALL have port cordic_cos, input, 9 bits, signed: cosine, value/256.
REQ-015 SHALL have port pt_valid, output, 1 bit: endpoint valid.
REQ-016 SHALL have port pt_ready, input, 1 bit: consumer accepts the endpoint.
REQ-017 SHALL have port pt_x, output, 10 bits: endpoint x.
REQ-018 SHALL have port pt_y, output, 10 bits: endpoint y.
REQ-019 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-020 SHALL implement the FSM IDLE -> START -> WAIT -> MUL -> OUT -> IDLE.
REQ-021 SHALL drive req_ready=1 only in IDLE; a request is accepted on req_valid&&req_ready, latching angle and radius, then moving to START.
REQ-022 SHALL reduce the angle at accept: latched angle >=360 becomes angle-360 (e.g. 400 -> 40, 511 -> 151); cordic_angle stays stable from START until the FSM leaves WAIT.
REQ-023 SHALL hold cordic_start high for exactly the one START cycle, then move to WAIT.
REQ-024 SHALL sample cordic_done only in WAIT; on the first cycle it is high, latch cordic_sin and cordic_cos and enter MUL; cordic_done high during START is ignored.
REQ-025 SHALL compute in MUL, over exactly RW cycles with an iterative shift-add (one radius bit per cycle, LSB first), the 17-bit signed products ps=sin*radius and pc=cos*radius, running both in parallel.
REQ-026 SHALL divide each product by 256 with truncation toward zero: non-negative -> arithmetic shift right 8; negative -> (p+255)>>>8.
REQ-027 SHALL set pt_x = CX + pc/256 and pt_y = CY - ps/256 (screen y grows downward), computed in 11-bit signed and truncated to 10 bits, i.e. modulo 1024.
REQ-028 SHALL enter OUT after MUL, with pt_valid=1 and pt_x/pt_y stable, until a cycle with pt_ready=1, then return to IDLE.
REQ-029 SHALL give latency from accept to pt_valid of 1 (START) + N + RW + 1, where N = WAIT cycles until cordic_done; with N=1 and RW=8 this is 11 cycles.
REQ-030 SHALL produce pt_x=CX, pt_y=CY for radius 0, still spending the full RW MUL cycles.
REQ-031 SHALL NOT accept a new request in the cycle OUT completes; req_ready rises the following cycle in IDLE.
REQ-032 SHALL keep WAIT indefinitely if cordic_done never rises; there is no timeout.

Reset
REQ-033 SHALL, when rst_n=0 (asynchronous, any state, including mid-MUL), force IDLE and clear req_ready, cordic_start, pt_valid, busy, pt_x, pt_y, cordic_angle and all internal registers to 0.
REQ-034 SHALL drive req_ready=1 in the first clock cycle after rst_n deasserts.
REQ-035 SHALL discard any in-flight request on reset and emit no partial point.

Verification
REQ-036 SHALL be verified by: angle 0, radius 100, model returns cos=255, sin=0 after 1 cycle -> pt_x=419, pt_y=240, pt_valid 11 cycles after accept.
REQ-037 SHALL be verified by: angle 90, radius 100, sin=255, cos=0 -> pt_x=320, pt_y=141; angle 180, cos=-255, sin=0 -> pt_x=221, pt_y=240 (toward-zero rounding).
REQ-038 SHALL be verified by: angle 400, radius 50 -> cordic_angle=40 while cordic_start pulses for exactly one cycle; angle 511 -> cordic_angle=151.
REQ-039 SHALL be verified by: pt_ready held 0 for 5 cycles in OUT -> pt_valid, pt_x and pt_y stay constant, req_ready stays 0, and a new req_valid is not accepted.
REQ-040 SHALL be verified by: rst_n pulsed low during cycle 3 of MUL -> all outputs 0 immediately, req_ready=1 in the first cycle after release, no pt_valid for the aborted request.
REQ-041 SHALL be verified by: radius 0 with any sin/cos -> pt_x=320, pt_y=240; cordic_done high during START only, then low for 3 cycles -> block stays in WAIT and completes only on the later done.

Source files
------------

// File: rtl/hand_point_gen.sv
// rtl/hand_point_gen.sv - clock-hand endpoint generator: angle reduce, sin/cos handshake, shift-add scale, screen offset
module hand_point_gen #(
  parameter int CX = 320,
  parameter int CY = 240,
  parameter int RW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [8:0]        req_angle,
  input  logic [RW-1:0]     req_radius,
  output logic              cordic_start,
  output logic [8:0]        cordic_angle,
  input  logic              cordic_done,
  input  logic signed [8:0] cordic_sin,
  input  logic signed [8:0] cordic_cos,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic [9:0]        pt_x,
  output logic [9:0]        pt_y,
  output logic              busy
);

  // Product width: 9-bit signed trig value times RW-bit unsigned radius
  localparam int PW = 9 + RW;
  localparam int CW = $clog2(RW + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(RW - 1);
  localparam logic signed [10:0] CX11 = 11'(CX);
  localparam logic signed [10:0] CY11 = 11'(CY);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    MUL   = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t               state;
  logic [RW-1:0]        radius_sr;
  logic signed [PW-1:0] sin_sh;
  logic signed [PW-1:0] cos_sh;
  logic signed [PW-1:0] ps_acc;
  logic signed [PW-1:0] pc_acc;
  logic [CW-1:0]        bit_cnt;

  logic signed [PW-1:0] ps_next;
  logic signed [PW-1:0] pc_next;
  logic signed [10:0]   x_next;
  logic signed [10:0]   y_next;

  // Divide by 256 rounding toward zero, so negative products do not floor away from zero
  function automatic logic signed [PW-1:0] div256(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] t;
    if (p[PW-1]) begin
      t = p + $signed(PW'(255));
    end else begin
      t = p;
    end
    return t >>> 8;
  endfunction

  // Partial products including this cycle's radius bit, and the screen point they imply
  always_comb begin
    ps_next = ps_acc;
    pc_next = pc_acc;
    if (radius_sr[0]) begin
      ps_next = ps_acc + sin_sh;
      pc_next = pc_acc + cos_sh;
    end
    x_next = CX11 + 11'(div256(pc_next));
    y_next = CY11 - 11'(div256(ps_next));
  end

  // Control FSM with registered handshake outputs and the iterative multiplier datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= 1'b0;
      cordic_start <= 1'b0;
      cordic_angle <= '0;
      pt_valid     <= 1'b0;
      pt_x         <= '0;
      pt_y         <= '0;
      busy         <= 1'b0;
      radius_sr    <= '0;
      sin_sh       <= '0;
      cos_sh       <= '0;
      ps_acc       <= '0;
      pc_acc       <= '0;
      bit_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready    <= 1'b0;
            busy         <= 1'b1;
            cordic_start <= 1'b1;
            radius_sr    <= req_radius;
            cordic_angle <= (req_angle >= 9'd360) ? (req_angle - 9'd360) : req_angle;
            state        <= START;
          end
        end
        START: begin
          cordic_start <= 1'b0;
          state        <= WAIT;
        end
        WAIT: begin
          if (cordic_done) begin
            sin_sh  <= PW'(cordic_sin);
            cos_sh  <= PW'(cordic_cos);
            ps_acc  <= '0;
            pc_acc  <= '0;
            bit_cnt <= '0;
            state   <= MUL;
          end
        end
        MUL: begin
          ps_acc    <= ps_next;
          pc_acc    <= pc_next;
          sin_sh    <= sin_sh <<< 1;
          cos_sh    <= cos_sh <<< 1;
          radius_sr <= radius_sr >> 1;
          if (bit_cnt == LAST_BIT) begin
            pt_x     <= x_next[9:0];
            pt_y     <= y_next[9:0];
            pt_valid <= 1'b1;
            state    <= OUT;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        OUT: begin
          if (pt_ready) begin
            pt_valid  <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hand_point_gen.sv
// tb/tb_hand_point_gen.sv - scoreboard bench for hand_point_gen
module tb_hand_point_gen;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [8:0]        req_angle;
  logic [7:0]        req_radius;
  logic              cordic_start;
  logic [8:0]        cordic_angle;
  logic              cordic_done;
  logic signed [8:0] cordic_sin;
  logic signed [8:0] cordic_cos;
  logic              pt_valid;
  logic              pt_ready;
  logic [9:0]        pt_x;
  logic [9:0]        pt_y;
  logic              busy;

  hand_point_gen #(.CX(320), .CY(240), .RW(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_angle    (req_angle),
    .req_radius   (req_radius),
    .cordic_start (cordic_start),
    .cordic_angle (cordic_angle),
    .cordic_done  (cordic_done),
    .cordic_sin   (cordic_sin),
    .cordic_cos   (cordic_cos),
    .pt_valid     (pt_valid),
    .pt_ready     (pt_ready),
    .pt_x         (pt_x),
    .pt_y         (pt_y),
    .busy         (busy)
  );

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    int         acc_cyc;
    int         lat;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic pv_q = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: each new point is popped against the scoreboard
  always @(negedge clk) begin
    if (pt_valid && !pv_q) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_point: got x=%0d y=%0d expected none", pt_x, pt_y);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("pt_x", 64'(pt_x), 64'(e.x));
        chk("pt_y", 64'(pt_y), 64'(e.y));
        chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
      end
    end
    pv_q = pt_valid;
  end

  task automatic do_req(input logic [8:0] ang, input logic [7:0] rad,
                        input logic signed [8:0] s, input logic signed [8:0] c,
                        input logic [8:0] exp_ang, input int wait_n, input bit dis,
                        input bit push, input logic [9:0] ex, input logic [9:0] ey);
    int t;
    exp_t e;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_angle  = ang;
    req_radius = rad;
    if (push) begin
      e.x = ex; e.y = ey; e.acc_cyc = cyc; e.lat = 10 + wait_n;
      sbq.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("start_pulse", 64'(cordic_start), 64'd1);
    chk("cordic_angle_start", 64'(cordic_angle), 64'(exp_ang));
    if (dis) begin
      cordic_done = 1'b1;
      cordic_sin  = 9'sd77;
      cordic_cos  = -9'sd77;
    end
    @(negedge clk);
    cordic_done = 1'b0;
    chk("start_one_cycle", 64'(cordic_start), 64'd0);
    chk("cordic_angle_wait", 64'(cordic_angle), 64'(exp_ang));
    repeat (wait_n - 1) @(negedge clk);
    if (dis) chk("still_wait", 64'({busy, pt_valid}), 64'b10);
    cordic_done = 1'b1;
    cordic_sin  = s;
    cordic_cos  = c;
    @(negedge clk);
    cordic_done = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_angle = '0; req_radius = '0;
    cordic_done = 1'b0; cordic_sin = '0; cordic_cos = '0; pt_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", 64'({req_ready, cordic_start, pt_valid, busy, pt_x, pt_y, cordic_angle}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    do_req(9'd0,   8'd100,  9'sd0,    9'sd255,  9'd0,   1, 1'b0, 1'b1, 10'd419, 10'd240); wait_idle();
    do_req(9'd90,  8'd100,  9'sd255,  9'sd0,    9'd90,  1, 1'b0, 1'b1, 10'd320, 10'd141); wait_idle();
    do_req(9'd180, 8'd100,  9'sd0,   -9'sd255,  9'd180, 1, 1'b0, 1'b1, 10'd221, 10'd240); wait_idle();
    do_req(9'd400, 8'd50,   9'sd165,  9'sd196,  9'd40,  2, 1'b0, 1'b1, 10'd358, 10'd208); wait_idle();
    do_req(9'd511, 8'd200,  9'sd124, -9'sd224,  9'd151, 1, 1'b0, 1'b1, 10'd145, 10'd144); wait_idle();
    do_req(9'd45,  8'd0,   -9'sd200,  9'sd100,  9'd45,  4, 1'b1, 1'b1, 10'd320, 10'd240); wait_idle();
    do_req(9'd360, 8'd1,   -9'sd1,   -9'sd1,    9'd0,   1, 1'b0, 1'b1, 10'd320, 10'd240); wait_idle();
    do_req(9'd359, 8'd255, -9'sd256, -9'sd256,  9'd359, 1, 1'b0, 1'b1, 10'd65,  10'd495); wait_idle();

    // Consumer stall in OUT with a competing request
    pt_ready = 1'b0;
    do_req(9'd0, 8'd100, 9'sd0, 9'sd255, 9'd0, 1, 1'b0, 1'b1, 10'd419, 10'd240);
    begin
      int t;
      t = 0;
      while (!pt_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
    end
    req_valid = 1'b1; req_angle = 9'd10; req_radius = 8'd10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(pt_valid), 64'd1);
      chk("stall_xy", 64'({pt_x, pt_y}), 64'({10'd419, 10'd240}));
      chk("stall_ready", 64'(req_ready), 64'd0);
    end
    pt_ready = 1'b1;
    @(negedge clk);
    chk("no_accept_on_out", 64'({busy, pt_valid, req_ready}), 64'b001);
    req_valid = 1'b0;
    @(negedge clk);

    // Reset during the third MUL cycle
    do_req(9'd30, 8'd100, 9'sd128, 9'sd221, 9'd30, 1, 1'b0, 1'b0, 10'd0, 10'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({req_ready, cordic_start, pt_valid, busy, pt_x, pt_y, cordic_angle}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", 64'(req_ready), 64'd1);
    repeat (15) @(negedge clk);
    chk("no_partial_point", 64'({busy, pt_valid}), 64'd0);

    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
